// File: rtl/pcie_tl_rx_mwr_axi_pkg.sv
// Shared header constants, AXI encodings and FSM state type for the PCIe RX
// memory-write to AXI bridge.
package pcie_tl_rx_mwr_axi_pkg;

  localparam logic [2:0] FMT_3DW_D      = 3'b010;
  localparam logic [2:0] FMT_4DW_D      = 3'b011;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;

  localparam int         HDR_FMT_LSB    = 29;
  localparam int         HDR_TYPE_LSB   = 24;
  localparam int         HDR_LEN_W      = 10;
  localparam int         HDR_LBE_LSB    = 4;
  localparam int         HDR_FBE_LSB    = 0;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_DEC,
    RX_AW,
    RX_W,
    RX_B,
    RX_RET
  } rx_state_e;

  // Posted data credits are 4-DW units, rounded up.
  function automatic logic [11:0] dw_to_credits(input logic [9:0] len);
    return ({2'b00, len} + 12'd3) >> 2;
  endfunction

endpackage

// File: rtl/pcie_tl_rx_mwr_axi_hdr_dec.sv
// Combinational decode of a registered TLP header into the fields the
// AXI replay needs, plus the MWr and length sanity checks.
module pcie_tl_rx_hdr_dec
  import pcie_tl_rx_mwr_axi_pkg::*;
#(
  parameter int MAX_PAYLOAD_DW = 4
) (
  input  logic [31:0] dw0_i,
  input  logic [31:0] dw1_i,
  input  logic [31:0] dw2_i,
  input  logic [31:0] dw3_i,
  output logic [31:0] addr_o,
  output logic [9:0]  len_o,
  output logic [3:0]  first_be_o,
  output logic [3:0]  last_be_o,
  output logic        is_mwr_o,
  output logic        malformed_o
);

  logic [2:0] fmt;
  logic [4:0] typ;
  logic       unused_hdr;

  assign fmt        = dw0_i[HDR_FMT_LSB +: 3];
  assign typ        = dw0_i[HDR_TYPE_LSB +: 5];
  assign len_o      = dw0_i[0 +: HDR_LEN_W];
  assign first_be_o = dw1_i[HDR_FBE_LSB +: 4];
  assign last_be_o  = dw1_i[HDR_LBE_LSB +: 4];

  // Byte lanes are carried by the BEs, so the burst address is DW aligned.
  assign addr_o = {(fmt == FMT_4DW_D) ? dw3_i[31:2] : dw2_i[31:2], 2'b00};

  assign is_mwr_o    = (typ == TYPE_MEM) && ((fmt == FMT_3DW_D) || (fmt == FMT_4DW_D));
  assign malformed_o = (len_o == 10'd0) || (len_o > 10'(MAX_PAYLOAD_DW));

  assign unused_hdr = ^{dw0_i[23:10], dw1_i[31:8], dw2_i[1:0], dw3_i[1:0]};

endmodule

// File: rtl/pcie_tl_rx_mwr_axi.sv
// PCIe RX transaction layer: replays one Memory Write TLP as a single AXI4 INCR
// burst, then returns posted credits. PCIE_TL_RX_STATS_EN adds event counters.
//
// state   | meaning
// IDLE    | ready for a TLP from the DLL
// DEC     | check registered header, drop unsupported/malformed
// AW      | present burst address until accepted
// W       | stream payload beats
// B       | wait for write response
// RET     | one-cycle posted credit return
module pcie_tl_rx_mwr_axi
  import pcie_tl_rx_mwr_axi_pkg::*;
#(
  parameter int MAX_PAYLOAD_DW = 4,
  parameter int TLP_W          = 128 + 32*MAX_PAYLOAD_DW,
  parameter int AXI_ID_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tlp_valid_i,
  input  logic [TLP_W-1:0]    tlp_i,
  output logic                tlp_ready_o,
  output logic [AXI_ID_W-1:0] awid_o,
  output logic [31:0]         awaddr_o,
  output logic [7:0]          awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [31:0]         wdata_o,
  output logic [3:0]          wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [AXI_ID_W-1:0] bid_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic                fc_valid_o,
  output logic [7:0]          fc_hdr_cr_o,
  output logic [11:0]         fc_data_cr_o,
  output logic                err_malformed_o,
  output logic                err_unsup_o,
`ifdef PCIE_TL_RX_STATS_EN
  output logic                err_slverr_o,
  output logic [31:0]         stat_tlp_cnt_o,
  output logic [15:0]         stat_drop_cnt_o,
  output logic [15:0]         stat_slverr_cnt_o
`else
  output logic                err_slverr_o
`endif
);

  localparam int IDX_W = (MAX_PAYLOAD_DW > 1) ? $clog2(MAX_PAYLOAD_DW) : 1;

  rx_state_e        state_q, state_d;
  logic [TLP_W-1:0] tlp_q, tlp_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic             dropped_q, dropped_d;

  logic [31:0] hdr_addr;
  logic [9:0]  hdr_len;
  logic [3:0]  hdr_fbe, hdr_lbe;
  logic        hdr_is_mwr, hdr_malformed;
  logic [31:0] payload [MAX_PAYLOAD_DW];
  logic        last_beat;
  logic        unused_bid;

  pcie_tl_rx_hdr_dec #(.MAX_PAYLOAD_DW(MAX_PAYLOAD_DW)) u_hdr_dec (
    .dw0_i       (tlp_q[TLP_W-1  -: 32]),
    .dw1_i       (tlp_q[TLP_W-33 -: 32]),
    .dw2_i       (tlp_q[TLP_W-65 -: 32]),
    .dw3_i       (tlp_q[TLP_W-97 -: 32]),
    .addr_o      (hdr_addr),
    .len_o       (hdr_len),
    .first_be_o  (hdr_fbe),
    .last_be_o   (hdr_lbe),
    .is_mwr_o    (hdr_is_mwr),
    .malformed_o (hdr_malformed)
  );

  always_comb begin
    for (int k = 0; k < MAX_PAYLOAD_DW; k++) begin
      payload[k] = tlp_q[TLP_W-129-32*k -: 32];
    end
  end

  assign last_beat  = (10'(beat_q) == hdr_len - 10'd1);
  assign awid_o     = '0;
  assign awsize_o   = AXI_SIZE_4B;
  assign awburst_o  = AXI_BURST_INCR;
  assign unused_bid = ^bid_i;

  always_comb begin
    state_d         = state_q;
    tlp_d           = tlp_q;
    beat_d          = beat_q;
    dropped_d       = dropped_q;
    tlp_ready_o     = 1'b0;
    awvalid_o       = 1'b0;
    awaddr_o        = '0;
    awlen_o         = '0;
    wvalid_o        = 1'b0;
    wdata_o         = '0;
    wstrb_o         = '0;
    wlast_o         = 1'b0;
    bready_o        = 1'b0;
    fc_valid_o      = 1'b0;
    fc_hdr_cr_o     = '0;
    fc_data_cr_o    = '0;
    err_malformed_o = 1'b0;
    err_unsup_o     = 1'b0;
    err_slverr_o    = 1'b0;
    // Outputs stay quiet while reset is held, whatever state is being left.
    if (!rst) begin
      unique case (state_q)
        RX_IDLE: begin
          tlp_ready_o = 1'b1;
          if (tlp_valid_i) begin
            tlp_d   = tlp_i;
            state_d = RX_DEC;
          end
        end
        RX_DEC: begin
          dropped_d = 1'b1;
          if (!hdr_is_mwr) begin
            err_unsup_o = 1'b1;
            state_d     = RX_RET;
          end else if (hdr_malformed) begin
            err_malformed_o = 1'b1;
            state_d         = RX_RET;
          end else begin
            dropped_d = 1'b0;
            state_d   = RX_AW;
          end
        end
        RX_AW: begin
          awvalid_o = 1'b1;
          awaddr_o  = hdr_addr;
          awlen_o   = 8'(hdr_len - 10'd1);
          if (awready_i) begin
            beat_d  = '0;
            state_d = RX_W;
          end
        end
        RX_W: begin
          wvalid_o = 1'b1;
          wdata_o  = payload[beat_q];
          wlast_o  = last_beat;
          if (beat_q == '0)  wstrb_o = hdr_fbe;
          else if (last_beat) wstrb_o = hdr_lbe;
          else                wstrb_o = 4'hF;
          if (wready_i) begin
            if (last_beat) state_d = RX_B;
            else           beat_d  = beat_q + 1'b1;
          end
        end
        RX_B: begin
          bready_o = 1'b1;
          if (bvalid_i) begin
            err_slverr_o = (bresp_i != AXI_RESP_OKAY);
            state_d      = RX_RET;
          end
        end
        RX_RET: begin
          fc_valid_o   = 1'b1;
          fc_hdr_cr_o  = 8'd1;
          fc_data_cr_o = dropped_q ? 12'd0 : dw_to_credits(hdr_len);
          state_d      = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      tlp_q     <= '0;
      beat_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tlp_q     <= tlp_d;
      beat_q    <= beat_d;
      dropped_q <= dropped_d;
    end
  end

`ifdef PCIE_TL_RX_STATS_EN
  logic [31:0] tlp_cnt_q, tlp_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] slverr_cnt_q, slverr_cnt_d;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_comb begin
    tlp_cnt_d    = tlp_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    slverr_cnt_d = slverr_cnt_q;
    if (fc_valid_o && (tlp_cnt_q != '1))
      tlp_cnt_d = tlp_cnt_q + 32'd1;
    if ((err_unsup_o || err_malformed_o) && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 16'd1;
    if (err_slverr_o && (slverr_cnt_q != '1))
      slverr_cnt_d = slverr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tlp_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      slverr_cnt_q <= '0;
    end else begin
      tlp_cnt_q    <= tlp_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      slverr_cnt_q <= slverr_cnt_d;
    end
  end

  assign stat_tlp_cnt_o    = tlp_cnt_q;
  assign stat_drop_cnt_o   = drop_cnt_q;
  assign stat_slverr_cnt_o = slverr_cnt_q;
`endif

endmodule

// File: tb/tb_pcie_tl_rx_mwr_axi.sv
// Directed self-checking bench for pcie_tl_rx_mwr_axi (default parameters).
module tb_pcie_tl_rx_mwr_axi;

  localparam int TLP_W = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             tlp_valid_i;
  logic [TLP_W-1:0] tlp_i;
  logic             tlp_ready_o;
  logic [3:0]       awid_o;
  logic [31:0]      awaddr_o;
  logic [7:0]       awlen_o;
  logic [2:0]       awsize_o;
  logic [1:0]       awburst_o;
  logic             awvalid_o, awready_i;
  logic [31:0]      wdata_o;
  logic [3:0]       wstrb_o;
  logic             wlast_o, wvalid_o, wready_i;
  logic [3:0]       bid_i;
  logic [1:0]       bresp_i;
  logic             bvalid_i, bready_o;
  logic             fc_valid_o;
  logic [7:0]       fc_hdr_cr_o;
  logic [11:0]      fc_data_cr_o;
  logic             err_malformed_o, err_unsup_o, err_slverr_o;
`ifdef PCIE_TL_RX_STATS_EN
  logic [31:0]      stat_tlp_cnt_o;
  logic [15:0]      stat_drop_cnt_o, stat_slverr_cnt_o;
`endif

  pcie_tl_rx_mwr_axi dut (
    .clk(clk), .rst(rst),
    .tlp_valid_i(tlp_valid_i), .tlp_i(tlp_i), .tlp_ready_o(tlp_ready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i), .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i),
    .bready_o(bready_o), .fc_valid_o(fc_valid_o), .fc_hdr_cr_o(fc_hdr_cr_o),
    .fc_data_cr_o(fc_data_cr_o), .err_malformed_o(err_malformed_o),
`ifdef PCIE_TL_RX_STATS_EN
    .stat_tlp_cnt_o(stat_tlp_cnt_o), .stat_drop_cnt_o(stat_drop_cnt_o),
    .stat_slverr_cnt_o(stat_slverr_cnt_o),
`endif
    .err_unsup_o(err_unsup_o), .err_slverr_o(err_slverr_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic stall_mode = 1'b0;

  // observation state filled by the monitor
  int hs_cyc = -1, aw_lat = -1, rdy_back = -1;
  int n_aw, n_awv, n_w, n_fc, n_unsup, n_mal, n_slv;
  logic [31:0] aw_addr, aw_prev, w_prev;
  logic [7:0]  aw_len;
  logic        aw_stall = 1'b0, w_stall = 1'b0;
  logic [31:0] w_data [8];
  logic [3:0]  w_strb [8];
  logic        w_last [8];
  logic [7:0]  fc_hdr;
  logic [11:0] fc_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    awready_i = 1'b1;
    wready_i  = 1'b1;
    forever begin
      @(posedge clk); #1;
      awready_i = stall_mode ? ((cyc % 2) != 0) : 1'b1;
      wready_i  = stall_mode ? ((cyc % 3) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tlp_valid_i && tlp_ready_o) begin
        hs_cyc = cyc; aw_lat = -1; rdy_back = -1;
      end else if (tlp_ready_o && rdy_back < 0 && hs_cyc >= 0) begin
        rdy_back = cyc - hs_cyc;
      end
      if (awvalid_o) begin
        n_awv++;
        if (aw_lat < 0) aw_lat = cyc - hs_cyc;
      end
      if (aw_stall) begin
        chk("aw_hold_valid", 32'(awvalid_o), 32'd1);
        chk("aw_hold_addr", awaddr_o, aw_prev);
      end
      aw_stall = awvalid_o && !awready_i;
      aw_prev  = awaddr_o;
      if (awvalid_o && awready_i) begin
        aw_addr = awaddr_o; aw_len = awlen_o; n_aw++;
      end
      if (w_stall) begin
        chk("w_hold_valid", 32'(wvalid_o), 32'd1);
        chk("w_hold_data", wdata_o, w_prev);
      end
      w_stall = wvalid_o && !wready_i;
      w_prev  = wdata_o;
      if (wvalid_o) chk("w_after_aw", 32'(n_aw), 32'd1);
      if (wvalid_o && wready_i && n_w < 8) begin
        w_data[n_w] = wdata_o; w_strb[n_w] = wstrb_o; w_last[n_w] = wlast_o; n_w++;
      end
      if (fc_valid_o) begin
        n_fc++; fc_hdr = fc_hdr_cr_o; fc_data = fc_data_cr_o;
      end
      if (err_unsup_o)     n_unsup++;
      if (err_malformed_o) n_mal++;
      if (err_slverr_o)    n_slv++;
    end else begin
      aw_stall = 1'b0;
      w_stall  = 1'b0;
    end
  end

  function automatic logic [TLP_W-1:0] mk(input logic [2:0] fmt, input logic [4:0] typ,
      input logic [9:0] len, input logic [3:0] lbe, input logic [3:0] fbe,
      input logic [31:0] a2, input logic [31:0] a3, input logic [31:0] p0,
      input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3);
    logic [TLP_W-1:0] t;
    t = '0;
    t[255 -: 32] = {fmt, typ, 14'h0, len};
    t[223 -: 32] = {24'h0, lbe, fbe};
    t[191 -: 32] = a2;
    t[159 -: 32] = a3;
    t[127 -: 32] = p0;
    t[95  -: 32] = p1;
    t[63  -: 32] = p2;
    t[31  -: 32] = p3;
    return t;
  endfunction

  task automatic clr();
    n_aw = 0; n_awv = 0; n_w = 0; n_fc = 0; n_unsup = 0; n_mal = 0; n_slv = 0;
  endtask

  task automatic present(input logic [TLP_W-1:0] t);
    int n;
    clr();
    @(posedge clk); #1;
    tlp_i = t; tlp_valid_i = 1'b1;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!tlp_ready_o && n < 50);
    chk("hs_ready", 32'(tlp_ready_o), 32'd1);
    @(posedge clk); #1;
    tlp_valid_i = 1'b0; tlp_i = '0;
  endtask

  task automatic send(input logic [TLP_W-1:0] t);
    int n;
    present(t);
    n = 0;
    while (n_fc == 0 && n < 200) begin @(negedge clk); #1; n++; end
    repeat (3) begin @(negedge clk); #1; end
    chk("fc_pulses", 32'(n_fc), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; tlp_valid_i = 1'b0; tlp_i = '0;
    bid_i = 4'h5; bresp_i = 2'b00; bvalid_i = 1'b1;
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(tlp_ready_o), 32'd0);
    chk("rst_awvalid", 32'(awvalid_o), 32'd0);
    chk("rst_wvalid", 32'(wvalid_o), 32'd0);
    chk("rst_fc_valid", 32'(fc_valid_o), 32'd0);
    chk("rst_awsize", 32'(awsize_o), 32'd2);
    chk("rst_awburst", 32'(awburst_o), 32'd1);
    chk("rst_awid", 32'(awid_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(tlp_ready_o), 32'd1);

    // 3DW, len 1: DW3 slot carries junk that must not be used as the address
    send(mk(3'b010, 5'd0, 10'd1, 4'h0, 4'h6, 32'h1000_0010, 32'hDEAD_BEEF,
            32'h1122_3344, 32'h0, 32'h0, 32'h0));
    chk("t1_aw_addr", aw_addr, 32'h1000_0010);
    chk("t1_aw_len", 32'(aw_len), 32'd0);
    chk("t1_aw_latency", 32'(aw_lat), 32'd2);
    chk("t1_beats", 32'(n_w), 32'd1);
    chk("t1_wdata", w_data[0], 32'h1122_3344);
    chk("t1_wstrb", 32'(w_strb[0]), 32'h6);
    chk("t1_wlast", 32'(w_last[0]), 32'd1);
    chk("t1_fc_hdr", 32'(fc_hdr), 32'd1);
    chk("t1_fc_data", 32'(fc_data), 32'd1);
    chk("t1_period", 32'(rdy_back), 32'd6);
    chk("t1_slverr", 32'(n_slv), 32'd0);

    // 4DW, len 4, AW and W backpressure
    stall_mode = 1'b1;
    send(mk(3'b011, 5'd0, 10'd4, 4'h3, 4'hF, 32'hAAAA_AAAA, 32'h2000_0000,
            32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333));
    stall_mode = 1'b0;
    chk("t2_aw_addr", aw_addr, 32'h2000_0000);
    chk("t2_aw_len", 32'(aw_len), 32'd3);
    chk("t2_beats", 32'(n_w), 32'd4);
    chk("t2_d0", w_data[0], 32'hA000_0000);
    chk("t2_d1", w_data[1], 32'hA111_1111);
    chk("t2_d2", w_data[2], 32'hA222_2222);
    chk("t2_d3", w_data[3], 32'hA333_3333);
    chk("t2_strb", {16'h0, w_strb[0], w_strb[1], w_strb[2], w_strb[3]}, 32'hFFF3);
    chk("t2_last", {28'h0, w_last[0], w_last[1], w_last[2], w_last[3]}, 32'h1);
    chk("t2_fc_data", 32'(fc_data), 32'd1);

    // MRd: unsupported, dropped
    send(mk(3'b000, 5'd0, 10'd1, 4'h0, 4'hF, 32'h4000_0000, 32'h0,
            32'h0, 32'h0, 32'h0, 32'h0));
    chk("t3_unsup", 32'(n_unsup), 32'd1);
    chk("t3_awvalid", 32'(n_awv), 32'd0);
    chk("t3_fc_hdr", 32'(fc_hdr), 32'd1);
    chk("t3_fc_data", 32'(fc_data), 32'd0);
    chk("t3_ready_back", 32'(rdy_back), 32'd3);

    // 3DW format with a non-memory type
    send(mk(3'b010, 5'b00100, 10'd1, 4'h0, 4'hF, 32'h4000_0000, 32'h0,
            32'h0, 32'h0, 32'h0, 32'h0));
    chk("t3b_unsup", 32'(n_unsup), 32'd1);
    chk("t3b_awvalid", 32'(n_awv), 32'd0);

    // length 0 and MAX+1: malformed
    send(mk(3'b010, 5'd0, 10'd0, 4'h0, 4'hF, 32'h5000_0000, 32'h0,
            32'h0, 32'h0, 32'h0, 32'h0));
    chk("t4a_malformed", 32'(n_mal), 32'd1);
    chk("t4a_unsup", 32'(n_unsup), 32'd0);
    chk("t4a_awvalid", 32'(n_awv), 32'd0);
    chk("t4a_wbeats", 32'(n_w), 32'd0);
    chk("t4a_fc_data", 32'(fc_data), 32'd0);
    send(mk(3'b011, 5'd0, 10'd5, 4'hF, 4'hF, 32'h0, 32'h5000_0000,
            32'h0, 32'h0, 32'h0, 32'h0));
    chk("t4b_malformed", 32'(n_mal), 32'd1);
    chk("t4b_awvalid", 32'(n_awv), 32'd0);
    chk("t4b_fc_hdr", 32'(fc_hdr), 32'd1);
    chk("t4b_fc_data", 32'(fc_data), 32'd0);

    // SLVERR response; low address bits dropped; len 2 BE use
    bresp_i = 2'b10;
    send(mk(3'b010, 5'd0, 10'd2, 4'h3, 4'hC, 32'h3000_0007, 32'h0,
            32'hB000_0000, 32'hB111_1111, 32'h0, 32'h0));
    bresp_i = 2'b00;
    chk("t5_aw_addr", aw_addr, 32'h3000_0004);
    chk("t5_aw_len", 32'(aw_len), 32'd1);
    chk("t5_strb", {24'h0, w_strb[0], w_strb[1]}, 32'hC3);
    chk("t5_last", {30'h0, w_last[0], w_last[1]}, 32'h1);
    chk("t5_d1", w_data[1], 32'hB111_1111);
    chk("t5_slverr", 32'(n_slv), 32'd1);
    chk("t5_fc_hdr", 32'(fc_hdr), 32'd1);
    chk("t5_fc_data", 32'(fc_data), 32'd1);

    // reset during beat 2 of 4
    present(mk(3'b010, 5'd0, 10'd4, 4'hF, 4'hF, 32'h6000_0000, 32'h0,
               32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003));
    n = 0;
    while (!(wvalid_o && wdata_o == 32'hC0DE_0002) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("t6_reach_beat2", wdata_o, 32'hC0DE_0002);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("t6_awvalid", 32'(awvalid_o), 32'd0);
    chk("t6_wvalid", 32'(wvalid_o), 32'd0);
    chk("t6_bready", 32'(bready_o), 32'd0);
    chk("t6_ready", 32'(tlp_ready_o), 32'd1);
    repeat (10) begin @(negedge clk); #1; end
    chk("t6_no_fc", 32'(n_fc), 32'd0);

    // recovery after the abandoned burst
    send(mk(3'b010, 5'd0, 10'd1, 4'h0, 4'h9, 32'h7000_0000, 32'h0,
            32'h7777_0000, 32'h0, 32'h0, 32'h0));
    chk("t7_aw_addr", aw_addr, 32'h7000_0000);
    chk("t7_wdata", w_data[0], 32'h7777_0000);
    chk("t7_wstrb", 32'(w_strb[0]), 32'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_tl_rx_mwr_axi.md
Name: pcie_tl_rx_mwr_axi

Overview:
- Receive-side transaction-layer block. Accepts one complete, flattened Memory Write TLP per handshake from the data link layer.
- Decodes the header and replays the TLP as a single AXI4 INCR write burst on the AW/W/B channels.
- After each TLP completes or is dropped, returns posted flow-control credits to the DLL.
- It is the counterpart of the TX path, which turns AXI writes into TLPs.

Parameters:
- MAX_PAYLOAD_DW, 4, largest accepted payload in DWs (1..16).
- TLP_W, 128+32*MAX_PAYLOAD_DW, flattened TLP width: 4-DW header slot plus payload.
- AXI_ID_W, 4, AXI ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- tlp_valid_i  in  1  DLL presents a TLP.
- tlp_i  in  TLP_W  flattened TLP.
- tlp_ready_o  out  1  TLP accepted when valid&ready.
- awid_o  out  AXI_ID_W  always 0.
- awaddr_o  out  32  burst byte address.
- awlen_o  out  8  beats-1.
- awsize_o  out  3  always 3'b010.
- awburst_o  out  2  always INCR (2'b01).
- awvalid_o  out  1.
- awready_i  in  1.
- wdata_o  out  32.
- wstrb_o  out  4.
- wlast_o  out  1.
- wvalid_o  out  1.
- wready_i  in  1.
- bid_i  in  AXI_ID_W  ignored.
- bresp_i  in  2.
- bvalid_i  in  1.
- bready_o  out  1.
- fc_valid_o  out  1  one-cycle credit return pulse.
- fc_hdr_cr_o  out  8  posted header credits returned.
- fc_data_cr_o  out  12  posted data credits returned.
- err_malformed_o  out  1  pulse: bad length/format, TLP dropped.
- err_unsup_o  out  1  pulse: not MWr, TLP dropped.
- err_slverr_o  out  1  pulse: bresp != OKAY.

Behaviour:
- Layout: header DW n = tlp_i[TLP_W-1-32n -: 32]; payload DW k = tlp_i[TLP_W-129-32k -: 32]. Payload always follows the 4-DW slot.
- DW0: fmt[31:29], type[28:24], length[9:0]. DW1: lastBE[7:4], firstBE[3:0].
- Address = DW2 for 3DW (fmt 3'b010), DW3 for 4DW (fmt 3'b011). Bits [1:0] forced to 0.
- FSM states: IDLE, DEC, AW, W, B, RET.
- IDLE: tlp_ready_o=1. On handshake, register tlp_i, go DEC. tlp_ready_o=0 in all other states; one TLP in flight.
- DEC: check the registered TLP.
  - type!=0 or fmt not in {010,011} -> pulse err_unsup_o, go RET.
  - length==0 or length>MAX_PAYLOAD_DW -> pulse err_malformed_o, go RET.
  - Otherwise go AW.
- AW:
  - awvalid_o=1 with awaddr_o, awlen_o=length-1.
  - All AW outputs stable until awready_i; then go W with beat=0.
- W:
  - wvalid_o=1; wdata_o = payload DW[beat].
  - wstrb_o: firstBE on beat 0; lastBE on beat length-1 when length>1; 4'hF otherwise.
  - wlast_o=1 on beat length-1.
  - Beat advances only on wvalid&wready. After the last beat go B.
- B: bready_o=1. On bvalid_i: pulse err_slverr_o if bresp_i!=2'b00; go RET.
- RET:
  - fc_valid_o=1 for one cycle, fc_hdr_cr_o=1.
  - fc_data_cr_o=ceil(length/4), or 0 when dropped by err_unsup_o/err_malformed_o.
  - Go IDLE.
- Latency, TLP handshake to awvalid_o: 2 cycles.
- Minimum TLP-to-TLP period, zero-wait AXI: length+5 cycles.
- No W before AW handshake. awvalid_o is never withdrawn once raised.
- Reset:
  - All outputs 0, except awsize_o=3'b010, awburst_o=2'b01, awid_o=0.
  - FSM -> IDLE; tlp_ready_o=1 in the first cycle after reset deasserts.
  - Reset mid-burst abandons the burst silently: no credit return.

Optional Feature:
- Macro: PCIE_TL_RX_STATS_EN.
- With it:
  - Ports stat_tlp_cnt_o[31:0], stat_drop_cnt_o[15:0], stat_slverr_cnt_o[15:0].
  - tlp_cnt counts every RET entry; drop_cnt counts unsup+malformed; slverr_cnt counts err_slverr_o pulses.
  - Counters saturate at all-ones and clear on rst.
- Without it: the ports and counters do not exist.

Decomposition:
- PCIe_PKG holds:
  - fmt/type localparams (FMT_3DW_D=3'b010, FMT_4DW_D=3'b011, TYPE_MEM=5'b0).
  - Header field offset constants.
  - The rx_state_e enum.
  - AXI_RESP_OKAY.
- One natural sub-module: pcie_tl_rx_hdr_dec. Combinational decode of the registered header into addr, length, first/last BE, is_mwr and malformed.

Test Plan:
- 3DW MWr, addr 0x1000_0010, len 1, firstBE 4'h6, awready/wready tied 1 -> AW addr 0x10000010 len 0; one beat strb 4'h6 wlast=1; fc_valid_o with hdr 1, data 1.
- 4DW MWr, DW3=0x2000_0000, len 4, first 4'hF, last 4'h3, random wready stalls -> 4 beats in order, strb F,F,F,3; data stable under stall; fc data 1.
- MRd TLP (fmt 3'b000) -> err_unsup_o one pulse; no awvalid_o; fc hdr 1, data 0; tlp_ready_o back to 1 after 3 cycles.
- MWr len 0 and len MAX_PAYLOAD_DW+1 -> err_malformed_o each; no AXI traffic.
- bresp=2'b10 -> err_slverr_o pulse; credits still returned.
- rst asserted during W beat 2 of 4 -> next cycle all valids 0, tlp_ready_o=1, no fc_valid_o pulse.
